// File: rtl/de_stage_register.sv
// Decode->execute pipeline register: operand bypass muxing, load-use bubbles,
// branch flush and the multdiv hold FSM that freezes DE while the unit works.

module de_operand_lane #(
   parameter int W = 32
) (
   input  logic [2:0]   bypass_sig,
   input  logic [W-1:0] rf_data,
   input  logic [W-1:0] de_result,
   input  logic [W-1:0] em_result,
   input  logic [W-1:0] mw_result,
   input  logic         de_is_lw,
   input  logic         em_is_lw,
   output logic [W-1:0] operand,
   output logic         hazard
);
   always_comb begin
      if (bypass_sig[2])      operand = de_result;
      else if (bypass_sig[1]) operand = em_result;
      else if (bypass_sig[0]) operand = mw_result;
      else                    operand = rf_data;
   end

   // A load result is not ready while it sits in DE, and an EM load only
   // matters when DE isn't the nearer producer.
   assign hazard = (bypass_sig[2] & de_is_lw) |
                   (~bypass_sig[2] & bypass_sig[1] & em_is_lw);
endmodule

module de_stage_register #(
   parameter logic [4:0] LW_OPCODE  = 5'b01000,
   parameter logic [4:0] ALU_OPCODE = 5'b00000,
   parameter logic [4:0] MUL_ALUOP  = 5'b00110,
   parameter logic [4:0] DIV_ALUOP  = 5'b00111,
   parameter int         MD_TIMEOUT = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] fd_instruction,
   input  logic [31:0] fd_pc,
   input  logic [31:0] rf_data_A,
   input  logic [31:0] rf_data_B,
   input  logic [2:0]  bypass_A_sig,
   input  logic [2:0]  bypass_B_sig,
   input  logic [31:0] de_result,
   input  logic [31:0] em_result,
   input  logic [31:0] mw_result,
   input  logic [31:0] em_instruction,
   input  logic        branch_flush,
   input  logic        multdiv_ready,
   output logic [31:0] de_instruction,
   output logic [31:0] de_pc,
   output logic [31:0] de_opA,
   output logic [31:0] de_opB,
   output logic        de_valid,
   output logic        stall_fd,
   output logic        multdiv_start,
   output logic        multdiv_busy,
   output logic        multdiv_timeout,
   output logic [31:0] stall_cycles
);
   localparam int NUM_LANES = 2;
   localparam int VEC_W     = 32;
   localparam int TW        = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(MD_TIMEOUT - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic        valid;
   } de_reg_t;

   state_t  state, next_state;
   de_reg_t de_q;
   logic [TW-1:0] timer;

   logic [NUM_LANES-1:0][VEC_W-1:0] lane_rf, lane_op;
   logic [NUM_LANES-1:0][2:0]       lane_byp;
   logic [NUM_LANES-1:0]            lane_haz;

   logic de_is_lw, em_is_lw, de_is_md, lu;
   logic de_load, de_bubble, timer_clr, timer_inc, set_timeout;
   logic unused_em_bits;

   assign lane_rf  = {rf_data_B, rf_data_A};
   assign lane_byp = {bypass_B_sig, bypass_A_sig};

   assign de_is_lw = de_q.valid & (de_q.instr[31:27] == LW_OPCODE);
   assign em_is_lw = em_instruction[31:27] == LW_OPCODE;
   assign de_is_md = de_q.valid & (de_q.instr[31:27] == ALU_OPCODE) &
                     ((de_q.instr[6:2] == MUL_ALUOP) | (de_q.instr[6:2] == DIV_ALUOP));
   assign unused_em_bits = ^em_instruction[26:0];

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      de_operand_lane #(.W(VEC_W)) u_lane (
         .bypass_sig (lane_byp[l]),
         .rf_data    (lane_rf[l]),
         .de_result  (de_result),
         .em_result  (em_result),
         .mw_result  (mw_result),
         .de_is_lw   (de_is_lw),
         .em_is_lw   (em_is_lw),
         .operand    (lane_op[l]),
         .hazard     (lane_haz[l])
      );
   end

   assign lu = |lane_haz;

   always_comb begin
      next_state    = state;
      stall_fd      = 1'b0;
      multdiv_start = 1'b0;
      multdiv_busy  = 1'b0;
      de_load       = 1'b0;
      de_bubble     = 1'b0;
      timer_clr     = 1'b0;
      timer_inc     = 1'b0;
      set_timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (branch_flush) begin
               de_bubble = 1'b1;
            end else if (de_is_md) begin
               multdiv_start = 1'b1;
               stall_fd      = 1'b1;
               timer_clr     = 1'b1;
               next_state    = BUSY;
            end else if (lu) begin
               stall_fd  = 1'b1;
               de_bubble = 1'b1;
            end else begin
               de_load = 1'b1;
            end
         end
         BUSY: begin
            // A flush cannot arrive here: the md is the oldest in-flight op.
            multdiv_busy = 1'b1;
            if (multdiv_ready || timer == T_LAST) begin
               set_timeout = ~multdiv_ready;
               next_state  = IDLE;
               if (lu) begin
                  stall_fd  = 1'b1;
                  de_bubble = 1'b1;
               end else begin
                  de_load = 1'b1;
               end
            end else begin
               stall_fd  = 1'b1;
               timer_inc = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state           <= IDLE;
         de_q            <= '0;
         timer           <= '0;
         multdiv_timeout <= 1'b0;
         stall_cycles    <= '0;
      end else begin
         state <= next_state;
         if (timer_clr)      timer <= '0;
         else if (timer_inc) timer <= timer + 1'b1;
         if (set_timeout) multdiv_timeout <= 1'b1;
         if (de_bubble) begin
            de_q <= '0;
         end else if (de_load) begin
            de_q.instr <= fd_instruction;
            de_q.pc    <= fd_pc;
            de_q.op_a  <= lane_op[0];
            de_q.op_b  <= lane_op[1];
            de_q.valid <= |fd_instruction;
         end
         if (stall_fd && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
      end
   end

   assign de_instruction = de_q.instr;
   assign de_pc          = de_q.pc;
   assign de_opA         = de_q.op_a;
   assign de_opB         = de_q.op_b;
   assign de_valid       = de_q.valid;
endmodule
